// File: rtl/xf_matrix_memory_pkg.sv
// Shared matrix-memory definitions: geometry, word-address split and the
// write-buffer entry format.
package xf_matrix_memory_pkg;

  localparam int XF_MATRIX_ROWS = 128;
  localparam int XF_ROW_WIDTH   = 128;
  localparam int XF_WORD_WIDTH  = 32;
  localparam int XF_LANES       = XF_ROW_WIDTH / XF_WORD_WIDTH;
  localparam int XF_WADDR_W     = 9;
  localparam int XF_ROW_AW      = 7;
  localparam int XF_LANE_AW     = 2;

  typedef logic [XF_ROW_AW-1:0]     xf_row_t;
  typedef logic [XF_LANE_AW-1:0]    xf_lane_t;
  typedef logic [XF_WORD_WIDTH-1:0] xf_word_t;

  typedef struct packed {
    xf_row_t  row;
    xf_lane_t lane;
    xf_word_t data;
  } xf_wr_entry_t;

  // Word address layout: [8:2] row, [1:0] lane.
  function automatic xf_row_t xf_addr_row(input logic [XF_WADDR_W-1:0] addr);
    return addr[XF_WADDR_W-1:XF_LANE_AW];
  endfunction

  function automatic xf_lane_t xf_addr_lane(input logic [XF_WADDR_W-1:0] addr);
    return addr[XF_LANE_AW-1:0];
  endfunction

endpackage

// File: rtl/xf_matrix_memory_if.sv
// Word-write / row-read bus of the matrix memory.
// Writes: a word transfers on a rising edge where wrEnable && wrReady; wrEnable
// may be held with stable wrAddr/wrData until then. Reads: mpEnable is never
// stalled, and mpValid marks mpData one cycle after each mpEnable.
interface xf_matrix_memory_if
  import xf_matrix_memory_pkg::*;
#(
  parameter int WIDTH = XF_ROW_WIDTH
);
  logic [XF_WADDR_W-1:0]    wrAddr;
  logic [XF_WORD_WIDTH-1:0] wrData;
  logic                     wrEnable;
  logic                     wrReady;
  logic [XF_ROW_AW-1:0]     mpAddr;
  logic                     mpEnable;
  logic [WIDTH-1:0]         mpData;
  logic                     mpValid;

  modport master (
    output wrAddr, wrData, wrEnable, mpAddr, mpEnable,
    input  wrReady, mpData, mpValid
  );

  modport slave (
    input  wrAddr, wrData, wrEnable, mpAddr, mpEnable,
    output wrReady, mpData, mpValid
  );
endinterface

// File: rtl/xf_write_buffer.sv
// Shift-register write FIFO (entry 0 is oldest) with per-entry row compare
// that overlays pending words onto a row being read.
module xf_write_buffer
  import xf_matrix_memory_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int WIDTH     = XF_ROW_WIDTH
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  xf_wr_entry_t push_entry,
  output logic         ready,
  input  logic         pop,
  output logic         not_empty,
  output xf_wr_entry_t head,
  input  xf_row_t      fwd_row,
  input  logic [WIDTH-1:0] fwd_base,
  output logic [WIDTH-1:0] fwd_data
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  xf_wr_entry_t   ent [BUF_DEPTH];
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic [CW-1:0]  slot;
  logic           do_push;
  logic           do_pop;

  assign do_push   = push && ready;
  assign do_pop    = pop && (count != '0);
  assign not_empty = (count != '0);
  assign head      = ent[0];
  assign slot      = do_pop ? count - CW'(1) : count;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + CW'(1);
    else if (!do_push && do_pop)
      count_nxt = count - CW'(1);
  end

  // ready is a flop so it never depends on this cycle's read request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
      ready <= 1'b1;
    end else begin
      count <= count_nxt;
      ready <= (count_nxt < CW'(BUF_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_pop) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++)
        ent[i] <= ent[i + 1];
    end
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (do_push && (CW'(i) == slot))
        ent[i] <= push_entry;
    end
  end

  // Oldest first, so the newest word for a lane wins.
  always_comb begin
    fwd_data = fwd_base;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if ((CW'(i) < count) && (ent[i].row == fwd_row))
        fwd_data[int'(ent[i].lane) * XF_WORD_WIDTH +: XF_WORD_WIDTH] = ent[i].data;
    end
  end

endmodule

// File: rtl/xf_matrix_memory.sv
// Single-port matrix row store: reads take the port with priority, buffered
// word writes drain on idle cycles and are forwarded into reads meanwhile.
module xf_matrix_memory
  import xf_matrix_memory_pkg::*;
#(
  parameter int ROWS      = XF_MATRIX_ROWS,
  parameter int WIDTH     = XF_ROW_WIDTH,
  parameter int BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  xf_matrix_memory_if.slave bus
);

  logic [WIDTH-1:0] mem [ROWS];
  logic [WIDTH-1:0] rd_merged;
  logic [WIDTH-1:0] mp_data;
  logic             mp_valid;
  logic             push;
  logic             pop;
  logic             not_empty;
  logic             ready;
  xf_wr_entry_t     wr_entry;
  xf_wr_entry_t     head;

  assign wr_entry = '{row:  xf_addr_row(bus.wrAddr),
                      lane: xf_addr_lane(bus.wrAddr),
                      data: bus.wrData};

  // Requests seen while resetn is low are dropped, including the drain.
  assign push = resetn && bus.wrEnable;
  assign pop  = resetn && !bus.mpEnable && not_empty;

  xf_write_buffer #(
    .BUF_DEPTH (BUF_DEPTH),
    .WIDTH     (WIDTH)
  ) u_write_buffer (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_entry (wr_entry),
    .ready      (ready),
    .pop        (pop),
    .not_empty  (not_empty),
    .head       (head),
    .fwd_row    (bus.mpAddr),
    .fwd_base   (mem[bus.mpAddr]),
    .fwd_data   (rd_merged)
  );

  // Array contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (pop)
      mem[head.row][int'(head.lane) * XF_WORD_WIDTH +: XF_WORD_WIDTH] <= head.data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mp_valid <= 1'b0;
      mp_data  <= '0;
    end else begin
      mp_valid <= bus.mpEnable;
      if (bus.mpEnable)
        mp_data <= rd_merged;
    end
  end

  assign bus.mpData  = mp_data;
  assign bus.mpValid = mp_valid;
  assign bus.wrReady = ready;

endmodule

// File: tb/tb_xf_matrix_memory.sv
// Bench for xf_matrix_memory: cycle-stepped driver, array+FIFO reference model
// and an expected-row queue compared against mpData.
module tb_xf_matrix_memory;
  import xf_matrix_memory_pkg::*;

  localparam int W = 128;

  typedef struct packed {
    logic [6:0]  row;
    logic [1:0]  lane;
    logic [31:0] data;
  } m_ent_t;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  xf_matrix_memory_if #(.WIDTH(W)) bus();

  xf_matrix_memory #(
    .ROWS      (128),
    .WIDTH     (W),
    .BUF_DEPTH (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // reference model and scoreboard
  logic [W-1:0] arr_m [128];
  m_ent_t       fifo_m [$];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_data = '0;
  logic [W-1:0] mon_e;
  logic         exp_vld = 1'b0;
  logic         prev_re = 1'b0;
  logic         prev_rst = 1'b1;
  logic         run = 1'b0;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] view(input logic [6:0] row);
    logic [W-1:0] r;
    r = arr_m[row];
    foreach (fifo_m[i])
      if (fifo_m[i].row == row)
        r[fifo_m[i].lane * 32 +: 32] = fifo_m[i].data;
    return r;
  endfunction

  // One clock cycle: drive at posedge+1, update the model, advance.
  task automatic step(input logic rn, input logic we, input logic [8:0] wa,
                      input logic [31:0] wd, input logic re, input logic [6:0] ra);
    logic   accept;
    logic   drain;
    m_ent_t e;
    exp_vld = prev_re;
    if (prev_rst) last_data = '0;
    resetn       = rn;
    bus.wrEnable = we;
    bus.wrAddr   = wa;
    bus.wrData   = wd;
    bus.mpEnable = re;
    bus.mpAddr   = ra;
    run = 1'b1;
    check("wrReady", W'(bus.wrReady), W'(fifo_m.size() < 2));
    if (!rn) begin
      fifo_m.delete();
      prev_re  = 1'b0;
      prev_rst = 1'b1;
    end else begin
      prev_rst = 1'b0;
      prev_re  = re;
      if (re) exp_q.push_back(view(ra));
      accept = we && (fifo_m.size() < 2);
      drain  = !re && (fifo_m.size() > 0);
      if (drain) begin
        e = fifo_m.pop_front();
        arr_m[e.row][e.lane * 32 +: 32] = e.data;
      end
      if (accept) fifo_m.push_back({wa[8:2], wa[1:0], wd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 7'h0);
  endtask

  task automatic wr(input logic [8:0] wa, input logic [31:0] wd);
    step(1'b1, 1'b1, wa, wd, 1'b0, 7'h0);
  endtask

  task automatic rd(input logic [6:0] ra);
    step(1'b1, 1'b0, 9'h0, 32'h0, 1'b1, ra);
  endtask

  // monitor at negedge
  always @(negedge clk) begin
    if (run) begin
      check("mpValid", W'(bus.mpValid), W'(exp_vld));
      if (exp_vld) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("mpData", bus.mpData, mon_e);
          last_data = mon_e;
        end
      end else begin
        check("mpData_hold", bus.mpData, last_data);
      end
    end
  end

  initial begin
    int wi;
    logic acc;
    bus.wrEnable = 1'b0;
    bus.wrAddr   = '0;
    bus.wrData   = '0;
    bus.mpEnable = 1'b0;
    bus.mpAddr   = '0;
    @(posedge clk);
    #1;
    // requests during reset must be ignored
    repeat (3) step(1'b0, 1'b1, 9'h0AB, 32'hFFFF_FFFF, 1'b1, 7'h05);

    // give every row a known random value
    for (int r = 0; r < 128; r++)
      for (int l = 0; l < 4; l++)
        wr(9'(r * 4 + l), $urandom);
    idle(2);

    // four lanes of row 0
    wr(9'h000, 32'h1111_1111);
    wr(9'h001, 32'h2222_2222);
    wr(9'h002, 32'h3333_3333);
    wr(9'h003, 32'h4444_4444);
    idle(2);
    rd(7'h00);
    idle(1);
    check("row0_literal", arr_m[0], 128'h44444444_33333333_22222222_11111111);

    // forwarded read while reads hold the port
    wr(9'h005, 32'hDEAD_BEEF);
    repeat (4) rd(7'h01);
    idle(2);
    rd(7'h01);
    idle(1);

    // writes stall behind continuous reads
    wi = 0;
    for (int c = 0; c < 6; c++) begin
      acc = (wi < 3) && (fifo_m.size() < 2);
      step(1'b1, wi < 3, 9'(8 + wi), 32'hC0DE_0000 + 32'(wi), 1'b1, 7'h02);
      if (acc) wi++;
    end
    while (wi < 3) begin
      acc = fifo_m.size() < 2;
      step(1'b1, 1'b1, 9'(8 + wi), 32'hC0DE_0000 + 32'(wi), 1'b0, 7'h00);
      if (acc) wi++;
    end
    idle(2);
    rd(7'h02);
    idle(1);

    // back-to-back same lane, newest wins
    wr(9'h010, 32'hAAAA_0000);
    wr(9'h010, 32'hBBBB_0000);
    rd(7'h04);
    idle(2);
    rd(7'h04);
    idle(1);

    // reset with a full buffer discards pending words
    step(1'b1, 1'b1, 9'h020, 32'h5555_AAAA, 1'b1, 7'h09);
    step(1'b1, 1'b1, 9'h021, 32'h6666_BBBB, 1'b1, 7'h09);
    step(1'b1, 1'b1, 9'h022, 32'h7777_CCCC, 1'b1, 7'h09);
    step(1'b0, 1'b1, 9'h023, 32'h8888_DDDD, 1'b1, 7'h09);
    idle(1);
    rd(7'h08);
    rd(7'h00);
    idle(1);

    // read-around-write on the last row
    rd(7'h7F);
    step(1'b1, 1'b1, 9'h1FF, 32'h7F7F_7F7F, 1'b1, 7'h7F);
    rd(7'h7F);
    idle(2);
    rd(7'h7F);
    idle(1);

    // random mix on a few rows to exercise forwarding
    for (int c = 0; c < 400; c++)
      step(1'b1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)));
    idle(3);
    for (int r = 0; r < 8; r++) rd(7'(r));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xf_matrix_memory.md
XF_MATRIX_MEMORY -- requirements
Module: xf_matrix_memory

Interface
REQ-001 SHALL have parameter ROWS, default 128, number of 128-bit matrix rows.
REQ-002 SHALL have parameter WIDTH, default 128, row width in bits (4 x 32-bit words).
REQ-003 SHALL have parameter BUF_DEPTH, default 2, write-buffer entries.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 wrAddr  input  9  word address; [8:2] row, [1:0] lane.
REQ-007 wrData  input  32  word to write.
REQ-008 wrEnable  input  1  write request; accepted when wrEnable & wrReady.
REQ-009 wrReady  output  1  write buffer can accept a word.
REQ-010 mpAddr  input  7  read row address.
REQ-011 mpEnable  input  1  read request, one row per cycle.
REQ-012 mpData  output  WIDTH  read row data.
REQ-013 mpValid  output  1  mpData holds the row requested one cycle earlier.

Function
REQ-014 Lane n of a row SHALL occupy bits [32n+31:32n]; lane 0 in [31:0].
REQ-015 Storage SHALL be a single-port ROWS x WIDTH array with per-lane write enables; one access (read or write) per cycle.
REQ-016 Read latency SHALL be exactly 1 cycle: mpEnable at cycle T -> mpValid=1, mpData=row(mpAddr) at T+1; mpValid=0 in any cycle not preceded by mpEnable.
REQ-017 Reads SHALL have absolute priority over writes; mpEnable is never stalled.
REQ-018 Accepted writes SHALL enter a BUF_DEPTH-entry FIFO (row, lane, data); wrReady = (count < BUF_DEPTH), registered, independent of the current cycle's mpEnable.
REQ-019 In any cycle with mpEnable=0 and count>0, the FIFO head SHALL be written to the array and popped.
REQ-020 Accept and drain in the same cycle SHALL leave count unchanged; sustained one-word-per-cycle writes with no reads SHALL never deassert wrReady.
REQ-021 Read data SHALL be the array row with every buffered entry targeting that row merged, oldest to newest, newest winning per lane.
REQ-022 A write accepted in cycle T SHALL be visible to reads issued at T+1 or later; a read issued in cycle T SHALL not see it.
REQ-023 A write draining in cycle T SHALL be visible (via array or forwarding) to any read from T+1 on; no read SHALL ever return stale data for an accepted write.
REQ-024 mpData SHALL hold its last value when mpValid=0.
REQ-025 Out-of-range rows do not exist (7-bit address covers ROWS=128); no wrap logic required.

Reset
REQ-026 On resetn=0: mpValid=0, mpData=0, FIFO emptied (pending writes discarded), wrReady=1 from the first cycle after reset release.
REQ-027 Array contents SHALL NOT be reset; a reset mid-burst SHALL leave already-drained rows intact.
REQ-028 Requests (mpEnable, wrEnable) during reset SHALL be ignored.

Structure
REQ-029 XF_MATRIX_ROWS, XF_ROW_WIDTH, XF_WORD_WIDTH and the lane/row address split SHALL live in the shared XF package/include.
REQ-030 The write FIFO with per-entry row comparators and forwarding merge SHALL be one sub-module, xf_write_buffer; the top holds the array, arbitration and read pipeline.

Verification
REQ-031 Write words 0x11111111..0x44444444 to addresses 0x000..0x003, idle 2 cycles, read row 0 -> mpValid next cycle, mpData=0x44444444_33333333_22222222_11111111.
REQ-032 Write 0xDEADBEEF to 0x005 at T, read row 1 at T+1 with mpEnable held high 4 cycles -> lane 1 = 0xDEADBEEF on every read (forwarded), drains on first idle cycle.
REQ-033 Hold mpEnable=1 while writing 3 words -> wrReady low after 2 accepts, third held until mpEnable drops, all 3 land in order.
REQ-034 Two writes to 0x010 (0xAAAA0000 then 0xBBBB0000) back to back, read row 4 -> lane 0 = 0xBBBB0000.
REQ-035 Fill FIFO during reads, assert resetn=0 one cycle -> mpValid=0, wrReady=1, buffered words absent from later reads; previously drained rows unchanged.
REQ-036 Read row 0x7F at T, T+1, T+2 with 0x7F written at T+1 -> reads at T and T+1 old data, T+2 new data.
